// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, registered read data, occupancy count and coded errors.
// Define FIFO_WATERMARK_EN to build the almost_full / almost_empty comparators.
module sync_fifo_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic                         clear,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         error,
    output logic [2:0]                   err_code
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_ext: DEPTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1 || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_levels
        $error("sync_fifo_ext: watermark level out of range");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, full_q;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  error_q;
    logic [2:0]            err_code_q, err_code_d;
    logic                  mem_we, rd_load, rd_bypass;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? LAST_PTR : p - 1'b1;
    endfunction

    // Command decode: first matching row wins; reset suppresses every command.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        err_code_d = 3'd0;
        mem_we     = 1'b0;
        rd_load    = 1'b0;
        rd_bypass  = 1'b0;
        if (RESET) begin
            if (clear && (wr_en || rd_en)) begin
                err_code_d = 3'd4;
            end else if (clear) begin
                if (count_q == '0) begin
                    err_code_d = 3'd3;
                end else begin
                    wr_ptr_d = ptr_dec(wr_ptr_q);
                    count_d  = count_q - 1'b1;
                end
            end else if (wr_en && rd_en) begin
                rd_load    = 1'b1;
                rd_valid_d = 1'b1;
                if (count_q == '0) begin
                    rd_bypass = 1'b1;
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end
            end else if (wr_en) begin
                if (count_q == FULL_CNT) begin
                    err_code_d = 3'd1;
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                    count_d  = count_q + 1'b1;
                end
            end else if (rd_en) begin
                if (count_q == '0) begin
                    err_code_d = 3'd2;
                end else begin
                    rd_load    = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = ptr_inc(rd_ptr_q);
                    count_d    = count_q - 1'b1;
                end
            end
        end
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // When full with simultaneous access, wr_ptr == rd_ptr: the read sees the old head.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rd_data_q <= '0;
        end else if (rd_load) begin
            rd_data_q <= rd_bypass ? wr_data : mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == FULL_CNT);
            rd_valid_q <= rd_valid_d;
            error_q    <= (err_code_d != 3'd0);
            err_code_q <= err_code_d;
        end
    end

`ifdef FIFO_WATERMARK_EN
    logic af_q, ae_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            af_q <= 1'b0;
            ae_q <= 1'b1;
        end else begin
            af_q <= (count_d >= CW'(AF_LEVEL));
            ae_q <= (count_d <= CW'(AE_LEVEL));
        end
    end

    assign almost_full  = af_q;
    assign almost_empty = ae_q;
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign count      = count_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
- Parametrised successor of the team's single-clock circular-buffer FIFO.
- Generalised in data width and depth; depth need not be a power of two.
- Adds simultaneous read+write at any fill level, an occupancy count, registered read data with a valid strobe, encoded error reporting and optional watermark flags.
- Retains clear (drop newest entry) and empty bypass.
- Sits between a producer and consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8: width of each stored word.
- DEPTH, 16: number of entries; legal range DEPTH >= 2, any integer.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL; legal 1..DEPTH-1.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; legal 0..DEPTH-1.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-low reset (0 = reset).
- wr_en  in  1  push wr_data.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  pop oldest word.
- clear  in  1  discard newest stored word.
- rd_data  out  DATA_WIDTH  registered read word.
- rd_valid  out  1  rd_data holds a word popped on the previous edge.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  current occupancy.
- almost_full  out  1  watermark flag (see Optional Feature).
- almost_empty  out  1  watermark flag (see Optional Feature).
- error  out  1  one-cycle pulse, the cycle after an illegal command.
- err_code  out  3  cause of error; valid while error=1, otherwise 0.

Behaviour:
- Reset (RESET=0 at the edge):
  - Pointers = 0, count = 0, fifo_empty = 1, fifo_full = 0.
  - rd_valid = 0, rd_data = 0, error = 0, err_code = 0.
  - almost_empty = 1, almost_full = 0.
  - Memory contents are not cleared. All commands are ignored and no error is raised.
  - Reset during any operation aborts it; state is as above on the next cycle.
- Pointers: wr_ptr and rd_ptr run 0..DEPTH-1 and wrap DEPTH-1 -> 0 explicitly; there is no modulo-2^n assumption.
- Flags are registered and derived from the count value after the edge.
- Per-cycle command decode (RESET=1), first match wins:
  - clear with wr_en or rd_en: no state change; err_code 4.
  - clear, empty: no change; err_code 3.
  - clear, not empty: wr_ptr decrements with wrap 0 -> DEPTH-1; count-1.
  - wr_en and rd_en, empty: bypass. Nothing is stored and pointers are unchanged. Next cycle rd_data = wr_data, rd_valid = 1.
  - wr_en and rd_en, not empty (including full): head is popped to rd_data and wr_data is written at wr_ptr. Both pointers advance; count is unchanged; rd_valid = 1 next cycle.
  - wr_en only, full: dropped, no state change; err_code 1.
  - wr_en only, not full: write at wr_ptr; wr_ptr+1; count+1.
  - rd_en only, empty: no change; rd_valid = 0; err_code 2.
  - rd_en only, not empty: rd_data <= mem[rd_ptr]; rd_ptr+1; count-1; rd_valid = 1 next cycle.
  - none: hold.
- Read latency is 1 cycle. rd_data holds its last value when rd_valid = 0.
- error and err_code register on the edge following the offending command and last exactly one cycle.
- Error codes: 0 none, 1 overflow, 2 underflow, 3 clear-empty, 4 illegal combination.

Optional Feature:
- Macro FIFO_WATERMARK_EN.
- Defined: almost_full = (count >= AF_LEVEL) and almost_empty = (count <= AE_LEVEL), registered alongside the other flags.
- Undefined: almost_full is tied to 0 and almost_empty is tied to 0; the comparators are not built.

Test Plan:
- Fill and drain, DEPTH=5, DATA_WIDTH=8:
  - Write 0x11..0x55 -> fifo_full=1, count=5.
  - Sixth write 0x66 -> error=1, err_code=1, count stays 5.
  - Five reads -> rd_data 0x11..0x55, each with rd_valid=1.
  - Sixth read -> err_code=2.
- Wrap-around, DEPTH=5:
  - Repeat write 3 / read 3 four times -> data returned in order; count returns to 0 each round; pointers wrap past 4.
- Full simultaneous, DEPTH=5:
  - With the FIFO full, wr_en=rd_en=1, wr_data=0xAA -> rd_data=0x11, count stays 5, error=0.
  - Drain -> 0xAA is the last word out.
- Bypass and clear:
  - Empty FIFO, wr_en=rd_en=1, wr_data=0x3C -> next cycle rd_data=0x3C, rd_valid=1, count=0.
  - Write 0x01, 0x02, then clear -> count=1; the next read returns 0x01.
  - Clear again twice -> the second clear gives err_code=3.
- Reset and illegal combinations:
  - clear+wr_en -> err_code=4, no state change.
  - Drive RESET=0 mid-fill at count=3 with wr_en=1 -> count=0, fifo_empty=1, error=0.
- FIFO_WATERMARK_EN defined, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2:
  - almost_empty deasserts at count=3.
  - almost_full asserts at count=14 and deasserts at 13.
